// File: rtl/adder_bist_pkg.sv
// adder_bist_pkg: FSM state encoding and width helpers shared by the adder BIST engine
package adder_bist_pkg;
  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} bist_state_e;
  function automatic int tc_w(int n);
    return 2 * n + 1;
  endfunction
  function automatic int cnt_w(int settle);
    return settle > 1 ? $clog2(settle) : 1;
  endfunction
endpackage

// File: rtl/adder_bist_engine_if.sv
// adder_bist_engine_if: control/status and adder-under-test bus of the BIST engine
// master = engine (drives a, b, status; receives start, dut_s, dut_cout), slave = environment
interface adder_bist_engine_if
  import adder_bist_pkg::*;
#(
  parameter int N     = 8,
  parameter int ERR_W = 21
);
  logic                 start;
  logic [N-1:0]         a;
  logic [N-1:0]         b;
  logic [N-1:0]         dut_s;
  logic                 dut_cout;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [tc_w(N)-1:0]   test_count;
  logic [ERR_W-1:0]     err_count;
  logic [N-1:0]         fail_a;
  logic [N-1:0]         fail_b;
  modport master(input start, dut_s, dut_cout,
                 output a, b, busy, done, pass, test_count, err_count, fail_a, fail_b);
  modport slave(output start, dut_s, dut_cout,
                input a, b, busy, done, pass, test_count, err_count, fail_a, fail_b);
endinterface

// File: rtl/adder_bist_ref.sv
// adder_bist_ref: golden reference adder, exp = a + b with carry as the MSB
// a, b: operands; exp: N+1 bit expected {cout,s}
module adder_bist_ref
  import adder_bist_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N:0]   exp
);
  assign exp = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/adder_bist_engine.sv
// adder_bist_engine: walks every {a,b} pair through an N-bit adder, checks {cout,s}, counts errors
// clk, reset (async active-low); bus: start in, a/b out, dut_s/dut_cout in, busy/done/pass/test_count/err_count/fail_a/fail_b out
module adder_bist_engine
  import adder_bist_pkg::*;
#(
  parameter int N            = 8,
  parameter int SETTLE       = 4,
  parameter int ERR_W        = 21,
  parameter int STOP_ON_FAIL = 0
) (
  input logic clk,
  input logic reset,
  adder_bist_engine_if.master bus
);
  localparam int CW = cnt_w(SETTLE);
  bist_state_e state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [2*N-1:0]   vec, vec_n, fv, fv_n;
  logic [2*N:0]     tc, tc_n;
  logic [ERR_W-1:0] err, err_n;
  logic busy, busy_n, done, done_n, pass, pass_n;
  logic [N:0] exp;
  logic miss, stop;
  adder_bist_ref #(.N(N)) u_ref (.a(vec[2*N-1:N]), .b(vec[N-1:0]), .exp(exp));
  // case-equality so that X/Z from the adder under test counts as a mismatch
  assign miss = {bus.dut_cout, bus.dut_s} !== exp;
  // the all-ones vector ends the run, so {a,b} never wraps
  assign stop = (&vec) || (miss && STOP_ON_FAIL != 0);
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    vec_n   = vec;
    tc_n    = tc;
    err_n   = err;
    fv_n    = fv;
    busy_n  = busy;
    done_n  = done;
    pass_n  = pass;
    case (state)
      IDLE, DONE: if (bus.start) begin
        state_n = APPLY;
        vec_n   = '0;
        tc_n    = '0;
        err_n   = '0;
        fv_n    = '0;
        busy_n  = 1'b1;
        done_n  = 1'b0;
        pass_n  = 1'b0;
      end
      APPLY: begin
        cnt_n   = CW'(SETTLE - 1);
        state_n = WAIT;
      end
      WAIT: begin
        state_n = cnt == '0 ? CHECK : WAIT;
        cnt_n   = cnt == '0 ? cnt : cnt - 1'b1;
      end
      CHECK: begin
        tc_n    = tc + 1'b1;
        err_n   = miss && !(&err) ? err + 1'b1 : err;
        fv_n    = miss && err == '0 ? vec : fv;
        state_n = stop ? DONE : APPLY;
        vec_n   = stop ? vec : vec + 1'b1;
        busy_n  = !stop;
        done_n  = stop;
        pass_n  = stop && err_n == '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      vec   <= '0;
      tc    <= '0;
      err   <= '0;
      fv    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      vec   <= vec_n;
      tc    <= tc_n;
      err   <= err_n;
      fv    <= fv_n;
      busy  <= busy_n;
      done  <= done_n;
      pass  <= pass_n;
    end
  assign bus.a          = vec[2*N-1:N];
  assign bus.b          = vec[N-1:0];
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = pass;
  assign bus.test_count = tc;
  assign bus.err_count  = err;
  assign bus.fail_a     = fv[2*N-1:N];
  assign bus.fail_b     = fv[N-1:0];
endmodule

// File: tb/tb_adder_bist_engine.sv
// tb_adder_bist_engine: six N=4 engines against ideal, stuck-at and delayed adders, checked by a timing model
module tb_adder_bist_engine;
  localparam int K = 6;
  // adder kind: 0 ideal, 1 s[0] stuck-at-0, 2 cout stuck-at-0, 3 output delayed 6 cycles
  localparam int KIND[K] = '{0, 1, 2, 3, 3, 1};
  localparam int SET[K]  = '{4, 4, 4, 4, 8, 1};
  localparam int STP[K]  = '{0, 0, 1, 0, 0, 0};
  localparam int EW[K]   = '{21, 21, 21, 21, 21, 5};
  logic clk = 1'b0;
  logic reset, start;
  always #5 clk = ~clk;
  // {busy[48], done[47], pass[46], a[45:42], b[41:38], test_count[37:29], err_count[28:8], fail_a[7:4], fail_b[3:0]}
  logic [48:0] o [K];
  int n_tests = 0, n_fail = 0;
  for (genvar i = 0; i < K; i++) begin : g
    adder_bist_engine_if #(.N(4), .ERR_W(EW[i])) bus ();
    logic [4:0] sum;
    logic [4:0] p [6];
    adder_bist_engine #(.N(4), .SETTLE(SET[i]), .ERR_W(EW[i]), .STOP_ON_FAIL(STP[i])) dut (
      .clk(clk), .reset(reset), .bus(bus.master));
    assign bus.start = start;
    assign sum = 5'(bus.a) + 5'(bus.b);
    always @(posedge clk) begin
      p[0] <= sum;
      for (int j = 1; j < 6; j++) p[j] <= p[j-1];
    end
    assign {bus.dut_cout, bus.dut_s} = KIND[i] == 1 ? (sum & 5'h1e) : KIND[i] == 2 ? (sum & 5'h0f) :
                                       KIND[i] == 3 ? p[5] : sum;
    assign o[i] = {bus.busy, bus.done, bus.pass, bus.a, bus.b, bus.test_count,
                   21'(bus.err_count), bus.fail_a, bus.fail_b};
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  // Does vector cur fail on adder k? A 6-cycle delayed adder sampled at SETTLE+2<=6 sees the previous vector.
  function automatic bit vec_fails(int k, int cur, int pv);
    int v, e, s, r;
    v = (KIND[k] == 3 && SET[k] + 2 <= 6) ? (cur == 0 ? pv : cur - 1) : cur;
    e = cur / 16 + cur % 16;
    s = v / 16 + v % 16;
    r = KIND[k] == 1 ? (s & 30) : KIND[k] == 2 ? (s & 15) : s;
    return r != e;
  endfunction
  // model: one vector checked every SETTLE+2 edges after the start edge
  bit         m_run [K], m_done [K];
  int         m_t [K];
  logic [8:0] m_tc [K];
  logic [20:0] m_err [K];
  logic [7:0] m_cur [K], m_pv [K], m_fv [K];
  always @(posedge clk or negedge reset)
    for (int k = 0; k < K; k++)
      if (!reset) begin
        m_run[k] <= 0; m_done[k] <= 0; m_t[k] <= 0; m_tc[k] <= '0;
        m_err[k] <= '0; m_cur[k] <= '0; m_pv[k] <= '0; m_fv[k] <= '0;
      end else if (!m_run[k] && start) begin
        m_run[k] <= 1; m_done[k] <= 0; m_t[k] <= 0; m_tc[k] <= '0;
        m_err[k] <= '0; m_cur[k] <= '0; m_pv[k] <= m_cur[k]; m_fv[k] <= '0;
      end else if (m_run[k]) begin
        m_t[k] <= m_t[k] + 1;
        if ((m_t[k] + 1) % (SET[k] + 2) == 0) begin
          m_tc[k] <= m_tc[k] + 1;
          if (vec_fails(k, int'(m_cur[k]), int'(m_pv[k]))) begin
            if (m_err[k] != 21'((1 << EW[k]) - 1)) m_err[k] <= m_err[k] + 1;
            if (m_err[k] == 0) m_fv[k] <= m_cur[k];
          end
          if (m_cur[k] == 8'hff || (STP[k] != 0 && vec_fails(k, int'(m_cur[k]), int'(m_pv[k])))) begin
            m_run[k] <= 0; m_done[k] <= 1;
          end else m_cur[k] <= m_cur[k] + 1;
        end
      end
  function automatic logic [48:0] expv(int k);
    return {m_run[k], m_done[k], m_done[k] && m_err[k] == 0, m_cur[k], m_tc[k], m_err[k], m_fv[k]};
  endfunction
  always @(negedge clk)
    if (reset === 1'b1)
      for (int k = 0; k < K; k++) chk($sformatf("cycle g%0d", k), 64'(o[k]), 64'(expv(k)));
  function automatic bit all_done();
    for (int k = 0; k < K; k++) if (!o[k][47]) return 0;
    return 1;
  endfunction
  task automatic wait_all();
    int n = 0;
    while (!all_done() && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("all done in budget", 64'(all_done()), 64'd1);
  endtask
  initial begin
    int n;
    reset = 1'b0;
    start = 1'b0;
    repeat (10) @(negedge clk);
    for (int k = 0; k < K; k++) chk($sformatf("reset g%0d", k), 64'(o[k]), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (600) @(negedge clk);
    chk("g0 100 vectors", 64'(o[0][37:29]), 64'd100);
    chk("g1 errors in 100", 64'(o[1][28:8]), 64'd50);
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < K; k++) chk($sformatf("abort g%0d", k), 64'(o[k]), 64'd0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    fork
      begin
        repeat (50) @(negedge clk);
        start = 1'b0;
      end
    join_none
    n = 0;
    while (!o[0][47] && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("g0 run length", 64'(n), 64'd1536);
    wait_all();
    chk("g0 count", 64'(o[0][37:29]), 64'd256);
    chk("g0 errors", 64'(o[0][28:8]), 64'd0);
    chk("g0 pass", 64'(o[0][46]), 64'd1);
    chk("g1 errors", 64'(o[1][28:8]), 64'd128);
    chk("g1 first fail", 64'(o[1][7:0]), 64'h01);
    chk("g1 pass", 64'(o[1][46]), 64'd0);
    chk("g2 count", 64'(o[2][37:29]), 64'd32);
    chk("g2 errors", 64'(o[2][28:8]), 64'd1);
    chk("g2 first fail", 64'(o[2][7:0]), 64'h1f);
    chk("g2 stop a,b", 64'(o[2][45:38]), 64'h1f);
    chk("g3 errors", 64'(o[3][28:8]), 64'd255);
    chk("g4 pass", 64'(o[4][46]), 64'd1);
    chk("g5 saturated", 64'(o[5][28:8]), 64'd31);
    chk("g5 count", 64'(o[5][37:29]), 64'd256);
    chk("g0 final a,b", 64'(o[0][45:38]), 64'hff);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("g1 restart", 64'(o[1]), 64'h1_0000_0000_0000);
    wait_all();
    chk("g3 stale restart errors", 64'(o[3][28:8]), 64'd256);
    chk("g0 rerun pass", 64'(o[0][46]), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
